// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
// Counter widths never drop to zero bits, even for parameter values of 1 or 2.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first requester at or above (last+1),
// searching upward and wrapping at NREQ.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int OW = $clog2(NREQ);

    logic [OW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((32'(last) + 32'(k)) % 32'(NREQ));
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencing for a shared tri-state bus.
// Every owner change passes through TURN_CYC all-released cycles; long holds are preempted.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = cnt_w(MAX_HOLD);
    localparam int TW = cnt_w(TURN_CYC);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [OW-1:0] LAST_INIT = OW'(NREQ - 1);

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_q;
    logic            busy_q;
    logic [HW-1:0]   hold_q;
    logic [TW-1:0]   turn_q;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] others_req;
    logic            hold_at_max;
    logic            release_now;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
        owner_mask            = '0;
        owner_mask[owner_q]   = 1'b1;
    end

    // Preemption only makes sense when someone else is actually waiting.
    assign others_req  = req & ~owner_mask;
    assign hold_at_max = (hold_q == HOLD_LAST);
    assign release_now = !req[owner_q] || (hold_at_max && (|others_req));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= LAST_INIT;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= GRANT;
                        gnt_q   <= pick_onehot;
                        owner_q <= pick_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_q <= TURN;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                        turn_q  <= '0;
                    end else if (!hold_at_max) begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                TURN: begin
                    // Arbitrate on the last turnaround edge so the new grant
                    // rises exactly TURN_CYC cycles after the old one fell.
                    if (turn_q == TURN_LAST) begin
                        if (pick_valid) begin
                            state_q <= GRANT;
                            gnt_q   <= pick_onehot;
                            owner_q <= pick_idx;
                            busy_q  <= 1'b1;
                            hold_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        turn_q <= turn_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt_q));

    a_busy_matches: assert property (@(posedge clk) disable iff (reset)
        busy_q == (|gnt_q));

    a_no_direct_handoff: assert property (@(posedge clk) disable iff (reset)
        (|gnt_q) |=> ((gnt_q == $past(gnt_q)) || (gnt_q == '0)));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter with TURN_CYC=1 and TURN_CYC=3 instances.
module tb_bus_arbiter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;

    logic [3:0] gnt,   gnt3;
    logic [1:0] owner, owner3;
    logic       busy,  busy3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] gv      [2];
    logic [1:0] ov      [2];
    logic       bv      [2];
    logic [3:0] last_nz [2];
    logic [3:0] prev_g  [2];
    logic [1:0] prev_o  [2];
    int         zrun    [2];
    int         turn_len[2] = '{1, 3};

    always #5 clk = ~clk;

    bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy)
    );

    bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURN_CYC(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt3),
        .owner (owner3),
        .busy  (busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected grant c cycles into a two-requester rotation with turnaround t.
    function automatic logic [3:0] rot_exp(input int c, input int t);
        if (c <= 8)         return 4'b0001;
        if (c <= 8 + t)     return 4'b0000;
        if (c <= 16 + t)    return 4'b0010;
        if (c <= 16 + 2*t)  return 4'b0000;
        return 4'b0001;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        total_cnt++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner); else pass_cnt++;
        total_cnt++;
        if (gnt3 !== 4'b0000) $display("FAIL reset_gnt3: got %b want 0000", gnt3); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++;
        if (owner !== 2'd0) $display("FAIL reset_first_owner: got %0d want 0", owner); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL reset_first_busy: got %b want 1", busy); else pass_cnt++;
    endtask

    task automatic test_alone();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            total_cnt++;
            if (gnt !== 4'b0100) $display("FAIL alone_hold c%0d: got %b want 0100", c, gnt); else pass_cnt++;
        end
        total_cnt++;
        if (owner !== 2'd2) $display("FAIL alone_owner: got %0d want 2", owner); else pass_cnt++;
        req = 4'b0000;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000) $display("FAIL alone_drop_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL alone_drop_busy: got %b want 0", busy); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (gnt !== 4'b0000) $display("FAIL alone_idle c%0d: got %b want 0000", c, gnt); else pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 23; c++) begin
            tick();
            total_cnt++;
            if (gnt !== rot_exp(c, 1))
                $display("FAIL rot_t1 c%0d: got %b want %b", c, gnt, rot_exp(c, 1));
            else pass_cnt++;
            total_cnt++;
            if (gnt3 !== rot_exp(c, 3))
                $display("FAIL rot_t3 c%0d: got %b want %b", c, gnt3, rot_exp(c, 3));
            else pass_cnt++;
            if (c == 17) begin
                total_cnt++;
                if (owner !== 2'd1) $display("FAIL rot_owner_c17: got %0d want 1", owner); else pass_cnt++;
            end
            if (c == 19) begin
                total_cnt++;
                if (owner !== 2'd0) $display("FAIL rot_owner_c19: got %0d want 0", owner); else pass_cnt++;
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] e1, e3;
        do_reset();
        req = 4'b1001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 3) req = 4'b1000;
            e1 = (c <= 3) ? 4'b0001 : (c == 4) ? 4'b0000 : 4'b1000;
            e3 = (c <= 3) ? 4'b0001 : (c <= 6) ? 4'b0000 : 4'b1000;
            total_cnt++;
            if (gnt !== e1) $display("FAIL release_t1 c%0d: got %b want %b", c, gnt, e1); else pass_cnt++;
            total_cnt++;
            if (gnt3 !== e3) $display("FAIL release_t3 c%0d: got %b want %b", c, gnt3, e3); else pass_cnt++;
        end
        total_cnt++;
        if (owner3 !== 2'd3) $display("FAIL release_owner3: got %0d want 3", owner3); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL mid_pre_gnt: got %b want 0010", gnt); else pass_cnt++;
        total_cnt++;
        if (owner !== 2'd1) $display("FAIL mid_pre_owner: got %0d want 1", owner); else pass_cnt++;
        tick();
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++;
        if (owner !== 2'd0) $display("FAIL mid_rst_owner: got %0d want 0", owner); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL mid_post_gnt: got %b want 0010", gnt); else pass_cnt++;
        total_cnt++;
        if (gnt3 !== 4'b0010) $display("FAIL mid_post_gnt3: got %b want 0010", gnt3); else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            last_nz[d] = 4'b0000;
            prev_g[d]  = 4'b0000;
            prev_o[d]  = 2'd0;
            zrun[d]    = 100;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            req = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            tick();
            gv[0] = gnt;   gv[1] = gnt3;
            ov[0] = owner; ov[1] = owner3;
            bv[0] = busy;  bv[1] = busy3;
            for (int d = 0; d < 2; d++) begin
                total_cnt++;
                if (!$onehot0(gv[d])) $display("FAIL rand_onehot dut%0d cyc%0d: gnt %b", d, cyc, gv[d]);
                else pass_cnt++;
                total_cnt++;
                if (bv[d] !== (|gv[d])) $display("FAIL rand_busy dut%0d cyc%0d: busy %b gnt %b", d, cyc, bv[d], gv[d]);
                else pass_cnt++;
                if (gv[d] != 4'b0000) begin
                    total_cnt++;
                    if (gv[d][ov[d]] !== 1'b1) $display("FAIL rand_owner_bit dut%0d cyc%0d: owner %0d gnt %b", d, cyc, ov[d], gv[d]);
                    else pass_cnt++;
                    if (last_nz[d] != 4'b0000 && gv[d] != last_nz[d]) begin
                        total_cnt++;
                        if (zrun[d] < turn_len[d])
                            $display("FAIL rand_turnaround dut%0d cyc%0d: gap %0d want >=%0d", d, cyc, zrun[d], turn_len[d]);
                        else pass_cnt++;
                    end
                    if (prev_g[d] != 4'b0000) begin
                        total_cnt++;
                        if (ov[d] !== prev_o[d]) $display("FAIL rand_owner_stable dut%0d cyc%0d: got %0d want %0d", d, cyc, ov[d], prev_o[d]);
                        else pass_cnt++;
                    end
                    last_nz[d] = gv[d];
                    zrun[d]    = 0;
                end else begin
                    zrun[d]++;
                end
                prev_g[d] = gv[d];
                prev_o[d] = ov[d];
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_alone();
        test_rotation();
        test_release();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
